// File: rtl/pipe_hazard_ctrl.sv
// Hazard scheduler for the 5-stage IF/ID/EX/MEM/WB pipeline.
// Tracks in-flight destination registers in EX/MEM/WB slots, selects operand
// forwarding for ID, inserts a single load-use bubble and freezes the pipe
// while data memory is busy.
module pipe_hazard_ctrl #(
    parameter int RA_W     = 5,
    parameter int CNT_W    = 16,
    parameter int WAIT_MAX = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [RA_W-1:0]  id_rs1,
    input  logic [RA_W-1:0]  id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [RA_W-1:0]  id_rd,
    input  logic             id_rf_we,
    input  logic             id_is_load,
    input  logic             mem_busy,
    output logic             pc_le,
    output logic             ifid_le,
    output logic             idex_bubble,
    output logic             pipe_freeze,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_LDUSE   = 2'd1,
        ST_MEMWAIT = 2'd2
    } state_t;

    localparam int WAIT_W = $clog2(WAIT_MAX + 2);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(WAIT_MAX + 1);

    state_t state_reg;
    state_t state_next;

    // Slot index 0 = EX, 1 = MEM, 2 = WB
    logic [2:0]      slot_valid_reg;
    logic [2:0]      slot_we_reg;
    logic [2:0]      slot_ld_reg;
    logic [RA_W-1:0] slot_rd_reg [3];

    logic [2:0] hit_a;
    logic [2:0] hit_b;
    logic       luh;

    logic [WAIT_W-1:0] wait_reg;
    logic [WAIT_W-1:0] wait_next;
    logic              mem_timeout_reg;
    logic [CNT_W-1:0]  stall_cnt_reg;

    // Per-slot operand match; r0 and unused operands never match
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_match
            assign hit_a[gi] = slot_valid_reg[gi] & slot_we_reg[gi] &
                               (slot_rd_reg[gi] == id_rs1) & (id_rs1 != '0) & id_use_rs1;
            assign hit_b[gi] = slot_valid_reg[gi] & slot_we_reg[gi] &
                               (slot_rd_reg[gi] == id_rs2) & (id_rs2 != '0) & id_use_rs2;
        end
    endgenerate

    assign luh = id_valid & slot_ld_reg[0] & (hit_a[0] | hit_b[0]);

    // Forwarding select: nearest producer wins; a load in EX cannot forward
    always_comb begin
        fwd_a_sel = 2'b00;
        fwd_b_sel = 2'b00;
        if (hit_a[0] && !slot_ld_reg[0]) fwd_a_sel = 2'b01;
        else if (hit_a[1])               fwd_a_sel = 2'b10;
        else if (hit_a[2])               fwd_a_sel = 2'b11;
        if (hit_b[0] && !slot_ld_reg[0]) fwd_b_sel = 2'b01;
        else if (hit_b[1])               fwd_b_sel = 2'b10;
        else if (hit_b[2])               fwd_b_sel = 2'b11;
    end

    // Next-state and pipeline control decode; mem_busy has priority over load-use
    always_comb begin
        state_next  = ST_RUN;
        pc_le       = 1'b1;
        ifid_le     = 1'b1;
        idex_bubble = 1'b0;
        pipe_freeze = 1'b0;
        if (reset) begin
            if (mem_busy) begin
                state_next  = ST_MEMWAIT;
                pc_le       = 1'b0;
                ifid_le     = 1'b0;
                pipe_freeze = 1'b1;
            end else begin
                case (state_reg)
                    // EX holds the bubble just injected, so no second stall here
                    ST_LDUSE: state_next = ST_RUN;
                    default: begin
                        if (luh) begin
                            state_next  = ST_LDUSE;
                            pc_le       = 1'b0;
                            ifid_le     = 1'b0;
                            idex_bubble = 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_reg <= ST_RUN;
        else        state_reg <= state_next;
    end

    // Scoreboard shift: advance unless frozen, bubble into EX on load-use
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            slot_valid_reg <= '0;
            slot_we_reg    <= '0;
            slot_ld_reg    <= '0;
            for (int i = 0; i < 3; i++) slot_rd_reg[i] <= '0;
        end else if (!pipe_freeze) begin
            slot_valid_reg <= {slot_valid_reg[1:0], id_valid & ~idex_bubble};
            slot_we_reg    <= {slot_we_reg[1:0], id_rf_we};
            slot_ld_reg    <= {slot_ld_reg[1:0], id_is_load};
            slot_rd_reg[0] <= id_rd;
            slot_rd_reg[1] <= slot_rd_reg[0];
            slot_rd_reg[2] <= slot_rd_reg[1];
        end
    end

    // Consecutive mem_busy counter, saturating at the timeout threshold
    always_comb begin
        wait_next = '0;
        if (mem_busy) wait_next = (wait_reg == WAIT_LIMIT) ? wait_reg : wait_reg + 1'b1;
    end

    // Wait counter and sticky timeout flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_reg        <= '0;
            mem_timeout_reg <= 1'b0;
        end else begin
            wait_reg <= wait_next;
            if (wait_next == WAIT_LIMIT) mem_timeout_reg <= 1'b1;
        end
    end

    // Saturating count of cycles in which the PC does not advance
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                              stall_cnt_reg <= '0;
        else if (!pc_le && stall_cnt_reg != '1)  stall_cnt_reg <= stall_cnt_reg + 1'b1;
    end

    assign mem_timeout = mem_timeout_reg;
    assign stall_cnt   = stall_cnt_reg;

endmodule
